// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by an internal word-addressed RAM.
// Write and read channels run independent FSMs with registered handshake
// outputs. FIXED and INCR bursts of up to 256 beats are served; WSTRB is
// honoured. Unsupported bursts (size other than one word, WRAP, reserved)
// are drained or padded with SLVERR so the master never stalls.
module axi_slave_ram #(
    parameter int S_AXI_ID_WIDTH   = 1,
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH   = 10
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    // write address channel
    input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic [2:0]                    S_AXI_AWSIZE,
    input  logic [1:0]                    S_AXI_AWBURST,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    // write data channel
    input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    // write response channel
    output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    // read address channel
    input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    // read data channel
    output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int STRB_WIDTH = S_AXI_DATA_WIDTH / 8;
    localparam int DEPTH      = 1 << MEM_ADDR_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_WORD   = 3'd2;

    localparam logic [MEM_ADDR_WIDTH-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // backing store
    logic [S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Address decode: word index taken from the byte address; upper bits
    // alias and the byte offset is ignored.
    // ------------------------------------------------------------------
    logic [MEM_ADDR_WIDTH-1:0] aw_idx;
    logic [MEM_ADDR_WIDTH-1:0] ar_idx;
    logic                      aw_bad;
    logic                      ar_bad;

    assign aw_idx = S_AXI_AWADDR[MEM_ADDR_WIDTH+1:2];
    assign ar_idx = S_AXI_ARADDR[MEM_ADDR_WIDTH+1:2];
    // WRAP (2'b10) and reserved (2'b11) both have bit 1 set
    assign aw_bad = (S_AXI_AWSIZE != SIZE_WORD) || S_AXI_AWBURST[1];
    assign ar_bad = (S_AXI_ARSIZE != SIZE_WORD) || S_AXI_ARBURST[1];

    // address bits that do not take part in the decode
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[S_AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2],
                                S_AXI_AWADDR[1:0],
                                S_AXI_ARADDR[S_AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2],
                                S_AXI_ARADDR[1:0]};

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_t                  w_state;
    logic [MEM_ADDR_WIDTH-1:0] w_idx;
    logic [7:0]                w_len;
    logic [7:0]                w_cnt;
    logic                      w_incr;
    logic                      w_bad;
    logic                      w_err;
    logic                      w_beat;

    assign w_beat = S_AXI_WVALID && S_AXI_WREADY;

    // Write FSM: accept AW, sink len+1 data beats, then hold the response
    // until the master takes it.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            S_AXI_BRESP   <= RESP_OKAY;
            w_idx         <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_incr        <= 1'b0;
            w_bad         <= 1'b0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    // raised one cycle after reset release or after B handshake
                    S_AXI_AWREADY <= 1'b1;
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        S_AXI_BID     <= S_AXI_AWID;
                        w_idx         <= aw_idx;
                        w_len         <= S_AXI_AWLEN;
                        w_cnt         <= '0;
                        w_incr        <= (S_AXI_AWBURST == BURST_INCR);
                        w_bad         <= aw_bad;
                        w_err         <= 1'b0;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end

                W_DATA: begin
                    if (w_beat) begin
                        if (w_incr) begin
                            w_idx <= w_idx + IDX_ONE;
                        end
                        w_cnt <= w_cnt + 8'd1;
                        if (w_cnt == w_len) begin
                            // the beat count alone ends the burst; WLAST only
                            // affects the response
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= (w_bad || w_err || !S_AXI_WLAST)
                                            ? RESP_SLVERR : RESP_OKAY;
                            w_state      <= W_RESP;
                        end else if (S_AXI_WLAST) begin
                            w_err <= 1'b1;
                        end
                    end
                end

                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end

                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // RAM write port: byte-masked update on every accepted good beat.
    // NOTE: RAM contents survive reset by design, so this block has no reset
    // term; adding one would also prevent mapping onto a memory macro.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_beat && !w_bad) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (S_AXI_WSTRB[i]) begin
                    mem[w_idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel state. r_idx always points at the word to fetch for the
    // beat after the one currently presented on RDATA.
    // ------------------------------------------------------------------
    r_state_t                  r_state;
    logic [MEM_ADDR_WIDTH-1:0] r_idx;
    logic [7:0]                r_len;
    logic [7:0]                r_cnt;
    logic                      r_incr;
    logic                      r_bad;

    // Read FSM: fetch the first word on the AR handshake, then one word per
    // accepted beat. Reading mem with <= returns the pre-write value when the
    // write port hits the same word in the same cycle.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RID     <= '0;
            r_idx         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_incr        <= 1'b0;
            r_bad         <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        S_AXI_RID     <= S_AXI_ARID;
                        r_len         <= S_AXI_ARLEN;
                        r_cnt         <= '0;
                        r_incr        <= (S_AXI_ARBURST == BURST_INCR);
                        r_bad         <= ar_bad;
                        r_idx         <= (S_AXI_ARBURST == BURST_INCR) ? ar_idx + IDX_ONE
                                                                       : ar_idx;
                        S_AXI_RDATA   <= ar_bad ? '0 : mem[ar_idx];
                        S_AXI_RRESP   <= ar_bad ? RESP_SLVERR : RESP_OKAY;
                        S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                        r_state       <= R_DATA;
                    end
                end

                R_DATA: begin
                    // RVALID is high for the whole of R_DATA; outputs hold
                    // while RREADY is low
                    if (S_AXI_RREADY) begin
                        if (S_AXI_RLAST) begin
                            S_AXI_RVALID  <= 1'b0;
                            S_AXI_RLAST   <= 1'b0;
                            S_AXI_ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            S_AXI_RDATA <= r_bad ? '0 : mem[r_idx];
                            if (r_incr) begin
                                r_idx <= r_idx + IDX_ONE;
                            end
                            r_cnt       <= r_cnt + 8'd1;
                            S_AXI_RLAST <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end

                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule
